// File: rtl/not_serial_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : not_serial_arbiter                                          |
// | Round-robin arbiter that streams a requester's word LSB-first        |
// | through one shared NOT cell and returns the inverted word.           |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+

module not_cell (
  input  logic i_a,
  output logic o_y
);
  assign o_y = ~i_a;
endmodule

module not_serial_arbiter #(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req0,
  input  logic [N-1:0] data0,
  input  logic         req1,
  input  logic [N-1:0] data1,
  output logic         ack0,
  output logic         ack1,
  output logic [N-1:0] result,
  output logic         busy,
  output logic         owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CW-1:0] c_last = CW'(N - 1);

  state_t        r_state;
  state_t        w_next;
  logic [N-1:0]  r_sr;
  logic [N-1:0]  r_result;
  logic [CW-1:0] r_cnt;
  logic          r_owner;
  logic          r_ptr;
  logic          w_grant;
  logic          w_winner;
  logic [N-1:0]  w_sel_data;
  logic          w_inv;

  not_cell u_not (
    .i_a (r_sr[0]),
    .o_y (w_inv)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Contention goes to the requester that was not served last.
  always_comb begin
    w_next   = r_state;
    w_grant  = 1'b0;
    w_winner = r_owner;
    case (r_state)
      IDLE: begin
        if (req0 && req1) begin
          w_grant  = 1'b1;
          w_winner = ~r_ptr;
        end else if (req0) begin
          w_grant  = 1'b1;
          w_winner = 1'b0;
        end else if (req1) begin
          w_grant  = 1'b1;
          w_winner = 1'b1;
        end
        if (w_grant) w_next = SHIFT;
      end
      SHIFT:   if (r_cnt == c_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    w_sel_data = w_winner ? data1 : data0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sr     <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_owner  <= 1'b0;
      r_ptr    <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_owner <= w_winner;
            r_ptr   <= w_winner;
            r_sr    <= w_sel_data;
            r_cnt   <= '0;
          end
        end
        SHIFT: begin
          // Inverted bits enter at the MSB so the word lands in order after N shifts.
          r_result <= {w_inv, r_result[N-1:1]};
          r_sr     <= r_sr >> 1;
          r_cnt    <= r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign ack0   = (r_state == DONE) && !r_owner;
  assign ack1   = (r_state == DONE) &&  r_owner;
  assign busy   = (r_state != IDLE);
  assign result = r_result;
  assign owner  = r_owner;

endmodule
`default_nettype wire
